// File: rtl/spi_adc_sampler_pkg.sv
// Shared types and constants for the SPI ADC sampler.
// Provides the frame FSM state enum, frame geometry and the command-bit helper.
package spi_adc_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_t;

  localparam int FRAME_SCLKS = 17;
  localparam int CMD_BITS    = 5;
  localparam int DATA_MSB_K  = 7;
  localparam int SAMPLE_W    = 10;

  // Command word {1,1,ch[2:0]} is sent first bit first; bits past it are zero.
  function automatic logic cmd_bit(input logic [2:0] ch, input logic [4:0] k);
    logic [CMD_BITS-1:0] cmd;
    logic [2:0]          idx;
    cmd = {2'b11, ch};
    idx = 3'(CMD_BITS - 1) - k[2:0];
    if (k < 5'(CMD_BITS)) return cmd[idx];
    return 1'b0;
  endfunction

endpackage

// File: rtl/spi_adc_sclk_gen.sv
// SCLK phase and bit counter: each SCLK period is CLK_DIV clk cycles low then
// CLK_DIV cycles high; bit index k runs 0..FRAME_SCLKS-1 while run is high.
module spi_adc_sclk_gen
  import spi_adc_sampler_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       sclk,
  output logic       low_end,
  output logic       high_end,
  output logic       frame_done,
  output logic [4:0] bit_k
);

  logic [7:0] phase_cnt;
  logic       phase_high;
  logic       phase_last;

  assign phase_last = (phase_cnt == 8'(CLK_DIV - 1));

  // Counters sit at the start of period 0 whenever the shifter is not running.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      phase_cnt  <= '0;
      phase_high <= 1'b0;
      bit_k      <= '0;
    end else if (phase_last) begin
      phase_cnt  <= '0;
      phase_high <= !phase_high;
      if (phase_high)
        bit_k <= (bit_k == 5'(FRAME_SCLKS - 1)) ? 5'd0 : bit_k + 5'd1;
    end else begin
      phase_cnt <= phase_cnt + 8'd1;
    end
  end

  assign sclk       = run && phase_high;
  assign low_end    = run && !phase_high && phase_last;
  assign high_end   = run && phase_high && phase_last;
  assign frame_done = high_end && (bit_k == 5'(FRAME_SCLKS - 1));

endmodule

// File: rtl/spi_adc_sampler.sv
// Round-robin SPI ADC sampler with per-window completion pulse.
// Optional build macro SPI_ADC_TEST_PATTERN_EN replaces ADC data with {channel, frame count}.
module spi_adc_sampler
  import spi_adc_sampler_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_CH     = 4,
  parameter int WINDOW_LEN = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic                adc_mosi,
  output logic [SAMPLE_W-1:0] SPI_Data,
  output logic [2:0]          Channel_Sel,
  output logic                Sample_Valid,
  output logic                Bit_Count_Reached
);

  state_t              state;
  state_t              state_next;
  logic [8:0]          timer;
  logic [2:0]          ch;
  logic [15:0]         sweep;
  logic                window_hit;
  logic                miso_s1;
  logic                miso_s2;
  logic [SAMPLE_W-2:0] shift_reg;
  logic [SAMPLE_W-1:0] captured;
  logic                sclk_level;
  logic                high_end;
  logic                frame_done;
  logic                low_end_unused;
  logic [4:0]          bit_k;
  logic                last_ch;
  logic                sweep_last;

  spi_adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (state == SHIFT),
    .sclk      (sclk_level),
    .low_end   (low_end_unused),
    .high_end  (high_end),
    .frame_done(frame_done),
    .bit_k     (bit_k)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    adc_cs_n   = 1'b1;
    adc_sclk   = 1'b0;
    adc_mosi   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = CS_SETUP;
      end
      CS_SETUP: begin
        adc_cs_n = 1'b0;
        adc_mosi = cmd_bit(ch, 5'd0);
        if (timer == 9'(CLK_DIV - 1)) state_next = SHIFT;
      end
      SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = sclk_level;
        adc_mosi = cmd_bit(ch, bit_k);
        if (frame_done) state_next = CS_HOLD;
      end
      CS_HOLD: begin
        adc_cs_n = 1'b0;
        if (timer == 9'(CLK_DIV - 1)) state_next = GAP;
      end
      GAP: begin
        if (timer == 9'(2 * CLK_DIV - 1)) state_next = enable ? CS_SETUP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Dwell timer for the fixed-length states; SHIFT is timed by the SCLK generator.
  always_ff @(posedge clk) begin
    if (reset || (state_next != state) || (state == IDLE) || (state == SHIFT))
      timer <= '0;
    else
      timer <= timer + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= adc_miso;
      miso_s2 <= miso_s1;
    end
  end

  // Data bits are taken at the end of each high phase; k=5,6 are the null bits.
  always_ff @(posedge clk) begin
    if (reset)
      shift_reg <= '0;
    else if (high_end && (bit_k >= 5'(DATA_MSB_K)))
      shift_reg <= {shift_reg[SAMPLE_W-3:0], miso_s2};
  end

`ifdef SPI_ADC_TEST_PATTERN_EN
  logic [6:0] frame_cnt [0:7];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) frame_cnt[i] <= '0;
    end else if (frame_done) begin
      frame_cnt[ch] <= frame_cnt[ch] + 7'd1;
    end
  end

  assign captured = {ch, frame_cnt[ch]};
`else
  assign captured = {shift_reg, miso_s2};
`endif

  assign last_ch    = (ch == 3'(NUM_CH - 1));
  assign sweep_last = (sweep == 16'(WINDOW_LEN - 1));

  // Window pulse trails the last sample of the window by one cycle via window_hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      SPI_Data          <= '0;
      Channel_Sel       <= '0;
      Sample_Valid      <= 1'b0;
      Bit_Count_Reached <= 1'b0;
      ch                <= '0;
      sweep             <= '0;
      window_hit        <= 1'b0;
    end else begin
      Sample_Valid      <= frame_done;
      Bit_Count_Reached <= window_hit;
      window_hit        <= 1'b0;
      if (frame_done) begin
        SPI_Data    <= captured;
        Channel_Sel <= ch;
        ch          <= last_ch ? 3'd0 : ch + 3'd1;
        if (last_ch) begin
          if (sweep_last) begin
            sweep      <= '0;
            window_hit <= 1'b1;
          end else begin
            sweep <= sweep + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Self-checking bench for spi_adc_sampler: behavioural ADC slave, sample scoreboard,
// table-driven data vectors and directed reset / enable / window sequences.
module tb_spi_adc_sampler;

  localparam int CLK_DIV    = 4;
  localparam int NUM_CH     = 4;
  localparam int WINDOW_LEN = 2;
  localparam int FRAME_CYC  = 38 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       adc_miso = 1'b0;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic       adc_mosi;
  logic [9:0] SPI_Data;
  logic [2:0] Channel_Sel;
  logic       Sample_Valid;
  logic       Bit_Count_Reached;

  int checks = 0;
  int errors = 0;

  spi_adc_sampler #(
    .CLK_DIV   (CLK_DIV),
    .NUM_CH    (NUM_CH),
    .WINDOW_LEN(WINDOW_LEN)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .adc_miso         (adc_miso),
    .adc_sclk         (adc_sclk),
    .adc_cs_n         (adc_cs_n),
    .adc_mosi         (adc_mosi),
    .SPI_Data         (SPI_Data),
    .Channel_Sel      (Channel_Sel),
    .Sample_Valid     (Sample_Valid),
    .Bit_Count_Reached(Bit_Count_Reached)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, got no event, required one", name);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
  endtask

  // Behavioural ADC slave: decodes the command, returns a chosen 10-bit value MSB first.
  typedef struct packed {
    logic [4:0] cmd;
    logic [9:0] val;
  } adc_frame_t;

  adc_frame_t adc_q[$];
  logic [9:0] override_val [8];
  logic       override_en  [8];
  int         rise_cnt = 0;
  logic [4:0] adc_cmd;
  logic [9:0] frame_val;
  logic       tail_ok;

  initial for (int i = 0; i < 8; i++) begin
    override_en[i]  = 1'b0;
    override_val[i] = '0;
  end

  always @(negedge adc_cs_n) begin
    rise_cnt  = 0;
    adc_cmd   = '0;
    tail_ok   = 1'b1;
    frame_val = 10'($urandom);
    adc_miso  = 1'($urandom);
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      if (rise_cnt < 5) adc_cmd = {adc_cmd[3:0], adc_mosi};
      else if (adc_mosi !== 1'b0) tail_ok = 1'b0;
      rise_cnt++;
      if (rise_cnt == 5) begin
        if (override_en[adc_cmd[2:0]]) frame_val = override_val[adc_cmd[2:0]];
        adc_q.push_back('{cmd: adc_cmd, val: frame_val});
      end
    end
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      if (rise_cnt >= 7 && rise_cnt <= 16) adc_miso = frame_val[16 - rise_cnt];
      else adc_miso = 1'($urandom);
    end
  end

  always @(posedge adc_cs_n) begin
    if (reset === 1'b0) begin
      checkOutput("sclk_rises_per_frame", rise_cnt, 17);
      checkOutput("mosi_tail_zero", tail_ok, 1);
    end
  end

  // Scoreboard: channel order, data, command, frame period and window pulses.
  int         exp_ch = 0;
  int         sweeps = 0;
  int         cyc = 0;
  int         last_sv_cyc = -1;
  logic       bcr_due = 1'b0;
  logic [6:0] tp_cnt [8];
  adc_frame_t fr;
  logic [9:0] exp_data;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_ch      = 0;
      sweeps      = 0;
      bcr_due     = 1'b0;
      last_sv_cyc = -1;
      adc_q.delete();
      for (int i = 0; i < 8; i++) tp_cnt[i] = '0;
    end else begin
      if (!enable) last_sv_cyc = -1;
      if (bcr_due || Bit_Count_Reached)
        checkOutput("bit_count_reached", Bit_Count_Reached, bcr_due);
      bcr_due = 1'b0;
      if (Sample_Valid) begin
        checkOutput("sv_bcr_exclusive", Bit_Count_Reached, 0);
        checkOutput("channel_sel", Channel_Sel, exp_ch);
        checkOutput("adc_queue_depth", adc_q.size(), 1);
        if (adc_q.size() > 0) begin
          fr = adc_q.pop_front();
          checkOutput("mosi_command", fr.cmd, {2'b11, 3'(exp_ch)});
`ifdef SPI_ADC_TEST_PATTERN_EN
          exp_data = {3'(exp_ch), tp_cnt[exp_ch]};
          tp_cnt[exp_ch] = tp_cnt[exp_ch] + 7'd1;
`else
          exp_data = fr.val;
`endif
          checkOutput("spi_data", SPI_Data, exp_data);
        end
        if (last_sv_cyc >= 0) checkOutput("sample_period", cyc - last_sv_cyc, FRAME_CYC);
        last_sv_cyc = cyc;
        if (exp_ch == NUM_CH - 1) begin
          sweeps++;
          if (sweeps == WINDOW_LEN) begin
            bcr_due = 1'b1;
            sweeps  = 0;
          end
        end
        exp_ch = (exp_ch + 1) % NUM_CH;
      end
    end
  end

  typedef struct {
    logic [2:0] ch;
    logic [9:0] adc_val;
    logic [9:0] exp_data;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit   found;
    int   sv_n;
    int   bcr_n;
    int   t;
    int   sv_at [17];
    int   bcr_at [2];
    int   first_ch;
    int   rises;
    int   cs_low;
    logic prev_sclk;

    vecs[0] = '{ch: 3'd2, adc_val: 10'h2A5, exp_data: 10'h2A5, exp_ch: 3'd2};
    vecs[1] = '{ch: 3'd0, adc_val: 10'h000, exp_data: 10'h000, exp_ch: 3'd0};
    vecs[2] = '{ch: 3'd1, adc_val: 10'h3FF, exp_data: 10'h3FF, exp_ch: 3'd1};
    vecs[3] = '{ch: 3'd3, adc_val: 10'h155, exp_data: 10'h155, exp_ch: 3'd3};
    vecs[4] = '{ch: 3'd0, adc_val: 10'h200, exp_data: 10'h200, exp_ch: 3'd0};
    vecs[5] = '{ch: 3'd3, adc_val: 10'h001, exp_data: 10'h001, exp_ch: 3'd3};

    applyStimulus(1'b1, 1'b1);
    stepCycles(3);
    checkOutput("reset_cs_n", adc_cs_n, 1);
    checkOutput("reset_sclk", adc_sclk, 0);
    checkOutput("reset_mosi", adc_mosi, 0);
    checkOutput("reset_spi_data", SPI_Data, 0);
    checkOutput("reset_channel_sel", Channel_Sel, 0);
    checkOutput("reset_sample_valid", Sample_Valid, 0);
    checkOutput("reset_bit_count", Bit_Count_Reached, 0);

    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      found = 0;
      for (int c = 0; c < 2 * FRAME_CYC && !found; c++) begin
        stepCycles(1);
        if (Sample_Valid) found = 1;
      end
      if (!found) reportTimeout("table_align");
      override_val[vecs[i].ch] = vecs[i].adc_val;
      override_en[vecs[i].ch]  = 1'b1;
      found = 0;
      for (int c = 0; c < (NUM_CH + 2) * FRAME_CYC && !found; c++) begin
        stepCycles(1);
        if (Sample_Valid && Channel_Sel == vecs[i].ch) found = 1;
      end
      if (!found) reportTimeout("table_sample");
      else begin
`ifndef SPI_ADC_TEST_PATTERN_EN
        checkOutput("table_data", SPI_Data, vecs[i].exp_data);
`endif
        checkOutput("table_channel", Channel_Sel, vecs[i].exp_ch);
      end
      override_en[vecs[i].ch] = 1'b0;
    end

    // Reset in the high phase of SCLK period k=9.
    found = 0;
    for (int c = 0; c < 2 * FRAME_CYC && !found; c++) begin
      stepCycles(1);
      if (adc_cs_n === 1'b0 && adc_sclk === 1'b1 && rise_cnt == 10) found = 1;
    end
    if (!found) reportTimeout("reach_k9");
    applyStimulus(1'b1, 1'b1);
    stepCycles(1);
    checkOutput("midreset_cs_n", adc_cs_n, 1);
    checkOutput("midreset_sclk", adc_sclk, 0);
    checkOutput("midreset_mosi", adc_mosi, 0);
    checkOutput("midreset_spi_data", SPI_Data, 0);
    checkOutput("midreset_channel_sel", Channel_Sel, 0);
    checkOutput("midreset_sample_valid", Sample_Valid, 0);
    stepCycles(2);

    // Window pulses: one cycle after the 8th and 16th samples.
    applyStimulus(1'b0, 1'b1);
    sv_n = 0;
    bcr_n = 0;
    first_ch = -1;
    t = 0;
    for (int c = 0; c < 18 * FRAME_CYC && sv_n < 16; c++) begin
      stepCycles(1);
      t++;
      if (Sample_Valid) begin
        sv_n++;
        sv_at[sv_n] = t;
        if (sv_n == 1) first_ch = Channel_Sel;
      end
      if (Bit_Count_Reached) begin
        if (bcr_n < 2) bcr_at[bcr_n] = t;
        bcr_n++;
      end
    end
    stepCycles(1);
    t++;
    if (Bit_Count_Reached) begin
      if (bcr_n < 2) bcr_at[bcr_n] = t;
      bcr_n++;
    end
    if (sv_n < 16) reportTimeout("window_samples");
    else begin
      checkOutput("first_channel_after_reset", first_ch, 0);
      checkOutput("window_pulse_count", bcr_n, 2);
      if (bcr_n >= 2) begin
        checkOutput("window_pulse_1_time", bcr_at[0], sv_at[8] + 1);
        checkOutput("window_pulse_2_time", bcr_at[1], sv_at[16] + 1);
      end
    end

    // Enable dropped in SCLK period k=3: frame completes, then stays idle.
    found = 0;
    for (int c = 0; c < 2 * FRAME_CYC && !found; c++) begin
      stepCycles(1);
      if (adc_cs_n === 1'b0 && adc_sclk === 1'b1 && rise_cnt == 4) found = 1;
    end
    if (!found) reportTimeout("reach_k3");
    applyStimulus(1'b0, 1'b0);
    sv_n = 0;
    rises = 0;
    prev_sclk = adc_sclk;
    for (int c = 0; c < 3 * FRAME_CYC; c++) begin
      stepCycles(1);
      if (Sample_Valid) sv_n++;
      if (adc_sclk && !prev_sclk) rises++;
      prev_sclk = adc_sclk;
    end
    checkOutput("drop_sample_count", sv_n, 1);
    checkOutput("drop_remaining_sclk", rises, 13);
    rises = 0;
    cs_low = 0;
    for (int c = 0; c < 2 * FRAME_CYC; c++) begin
      stepCycles(1);
      if (adc_sclk && !prev_sclk) rises++;
      if (!adc_cs_n) cs_low++;
      prev_sclk = adc_sclk;
    end
    checkOutput("idle_sclk_edges", rises, 0);
    checkOutput("idle_cs_low_cycles", cs_low, 0);

    // Random enable bursts with random ADC data.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1);
      stepCycles($urandom_range(150, 700));
      applyStimulus(1'b0, 1'b0);
      stepCycles($urandom_range(0, 250));
    end
    applyStimulus(1'b0, 1'b0);
    stepCycles(2 * FRAME_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
